// File: rtl/tlc_param.sv
// tlc_param: parametrised two-road traffic-light controller with an internal
// phase timer. It cycles highway and farm-road heads through green, yellow and
// all-red phases, and has a maintenance flash mode.
// Optional feature: define TLC_SENSOR_EN for demand-actuated farm-road
// service. Highway green then extends until a farm vehicle has been detected.
module tlc_param #(
  parameter int CW      = 31,
  parameter int T_AR    = 50000000,
  parameter int T_HG    = 1500000000,
  parameter int T_HY    = 150000000,
  parameter int T_FG    = 750000000,
  parameter int T_FY    = 150000000,
  parameter int T_FLASH = 25000000
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Flash,
  input  logic          FarmSensor,
  output logic [2:0]    state,
  output logic [CW-1:0] Count,
  output logic [1:0]    highwaySignal,
  output logic [1:0]    farmSignal
);

  typedef enum logic [2:0] {
    S_INIT  = 3'b000,
    S_HG    = 3'b001,
    S_HY    = 3'b010,
    S_AR1   = 3'b011,
    S_FG    = 3'b100,
    S_FY    = 3'b101,
    S_AR2   = 3'b110,
    S_FLASH = 3'b111
  } state_t;

  localparam logic [1:0] SIG_GREEN  = 2'b00;
  localparam logic [1:0] SIG_YELLOW = 2'b01;
  localparam logic [1:0] SIG_RED    = 2'b10;
  localparam logic [1:0] SIG_OFF    = 2'b11;

  // Last count value of each phase; the phase ends on the edge that sees it.
  localparam logic [CW-1:0] AR_LAST    = CW'(T_AR - 1);
  localparam logic [CW-1:0] HG_LAST    = CW'(T_HG - 1);
  localparam logic [CW-1:0] HY_LAST    = CW'(T_HY - 1);
  localparam logic [CW-1:0] FG_LAST    = CW'(T_FG - 1);
  localparam logic [CW-1:0] FY_LAST    = CW'(T_FY - 1);
  localparam logic [CW-1:0] FLASH_LAST = CW'(T_FLASH - 1);
  localparam logic [CW-1:0] ONE        = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          blink_q, blink_d;
  logic [1:0]    hwSig_q, hwSig_d;
  logic [1:0]    farmSig_q, farmSig_d;
  logic          hgGo;

`ifdef TLC_SENSOR_EN
  logic farmReq_q, farmReq_d;

  // A vehicle seen this cycle counts as demand straight away, so HG can
  // release on the very edge that samples the sensor pulse.
  assign hgGo = farmReq_q | FarmSensor;

  // Remember farm demand until the farm road is actually served.
  always_comb begin
    farmReq_d = farmReq_q | FarmSensor;
    if (state_d == S_FG && state_q != S_FG) begin
      farmReq_d = 1'b0;
    end
  end

  // Demand flag register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      farmReq_q <= 1'b0;
    end else begin
      farmReq_q <= farmReq_d;
    end
  end
`else
  logic unusedSensor;

  // Fixed-time cycle: highway green always ends on schedule.
  assign hgGo         = 1'b1;
  assign unusedSensor = FarmSensor;
`endif

  // Next state, phase counter and blink phase; Flash overrides every phase.
  always_comb begin
    state_d = state_q;
    count_d = count_q + ONE;
    blink_d = blink_q;
    if (Flash) begin
      state_d = S_FLASH;
      if (state_q != S_FLASH) begin
        count_d = '0;
        blink_d = 1'b1;
      end else if (count_q == FLASH_LAST) begin
        count_d = '0;
        blink_d = ~blink_q;
      end
    end else begin
      case (state_q)
        S_INIT:  if (count_q == AR_LAST) state_d = S_HG;
        S_HG: begin
          if (count_q >= HG_LAST) begin
            if (hgGo) begin
              state_d = S_HY;
            end else begin
              count_d = HG_LAST;
            end
          end
        end
        S_HY:    if (count_q == HY_LAST) state_d = S_AR1;
        S_AR1:   if (count_q == AR_LAST) state_d = S_FG;
        S_FG:    if (count_q == FG_LAST) state_d = S_FY;
        S_FY:    if (count_q == FY_LAST) state_d = S_AR2;
        S_AR2:   if (count_q == AR_LAST) state_d = S_HG;
        S_FLASH: state_d = S_INIT;
        default: state_d = S_INIT;
      endcase
      if (state_d != state_q) begin
        count_d = '0;
      end
    end
  end

  // Signal heads for the upcoming state, so they register on the same edge.
  always_comb begin
    hwSig_d   = SIG_RED;
    farmSig_d = SIG_RED;
    case (state_d)
      S_HG:    hwSig_d   = SIG_GREEN;
      S_HY:    hwSig_d   = SIG_YELLOW;
      S_FG:    farmSig_d = SIG_GREEN;
      S_FY:    farmSig_d = SIG_YELLOW;
      S_FLASH: begin
        if (blink_d) begin
          hwSig_d = SIG_YELLOW;
        end else begin
          hwSig_d   = SIG_OFF;
          farmSig_d = SIG_OFF;
        end
      end
      default: begin
        hwSig_d   = SIG_RED;
        farmSig_d = SIG_RED;
      end
    endcase
  end

  // State, counter, blink and signal-head registers; reset is all-red.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= S_INIT;
      count_q   <= '0;
      blink_q   <= 1'b1;
      hwSig_q   <= SIG_RED;
      farmSig_q <= SIG_RED;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      blink_q   <= blink_d;
      hwSig_q   <= hwSig_d;
      farmSig_q <= farmSig_d;
    end
  end

  assign state         = state_q;
  assign Count         = count_q;
  assign highwaySignal = hwSig_q;
  assign farmSignal    = farmSig_q;

endmodule

// File: doc/tlc_param.md
# tlc_param

Parametrised two-road traffic-light controller with an internal phase timer. It drives the highway and farm-road signal heads through a fixed green/yellow/all-red cycle, and adds a maintenance flash mode. A compile-time option enables demand-actuated operation from a farm-road vehicle sensor. It sits directly above the signal-head drivers and is clocked from the system clock; all phase durations are given in clock cycles.

## Interface
- CW, 31, width of the phase counter; every T_* must be ≤ 2^CW−1
- T_AR, 50000000, all-red clearance duration (init and both clearances)
- T_HG, 1500000000, highway green duration (minimum green when sensor mode is enabled)
- T_HY, 150000000, highway yellow duration
- T_FG, 750000000, farm green duration
- T_FY, 150000000, farm yellow duration
- T_FLASH, 25000000, half-period of the flash blink
- Clk  input  1  system clock, rising edge
- Rst_n  input  1  asynchronous active-low reset
- Flash  input  1  maintenance flash request, level, synchronous to Clk
- FarmSensor  input  1  farm-road vehicle detect, level, synchronous to Clk
- state  output  3  current state (debug)
- Count  output  CW  current phase counter (debug)
- highwaySignal  output  2  GREEN=00, YELLOW=01, RED=10, OFF=11
- farmSignal  output  2  same encoding

## Operation
- States and their encodings, with the signal pair shown as highway/farm:
  - INIT=000: RED/RED
  - HG=001: GREEN/RED
  - HY=010: YELLOW/RED
  - AR1=011: RED/RED
  - FG=100: RED/GREEN
  - FY=101: RED/YELLOW
  - AR2=110: RED/RED
  - FLASH=111: blink
- Cycle: INIT(T_AR) → HG(T_HG) → HY(T_HY) → AR1(T_AR) → FG(T_FG) → FY(T_FY) → AR2(T_AR) → HG.
- Count: cleared to 0 on every state change. Otherwise it increments each cycle. Phase expires when Count == T_x−1. Count never wraps.
- FLASH entry: Flash high at any edge → next state FLASH from any state. Flash wins over simultaneous phase expiry. Count and blink phase are cleared on entry.
- In FLASH: the blink bit starts lit and toggles when Count == T_FLASH−1, with Count cleared on each toggle.
  - Lit: highway YELLOW, farm RED.
  - Dark: both OFF.
- FLASH exit: Flash low → INIT, which always gives full T_AR all-red before HG.
- Unused/illegal state: none reachable; the default branch forces INIT.
- Signal outputs are registered and update on the same edge as state. No combinational path from inputs to outputs.

## Timing
- Reset (asynchronous on Rst_n low, released synchronously by design): state=INIT, Count=0, highwaySignal=RED, farmSignal=RED, FarmReq=0, blink=lit.
- A phase of duration T occupies exactly T cycles. The first cycle of the new phase follows the edge where Count == T−1.
- Reset asserted mid-phase: outputs go all-red immediately, with no wait for Clk.
- Flash latency: Flash sampled high at edge N → FLASH state and lit outputs valid after edge N.

## Configuration
- TLC_SENSOR_EN defined:
  - An internal FarmReq flag is set on any cycle FarmSensor=1, and cleared on entry to FG.
  - HG holds past T_HG until FarmReq=1; the transition to HY occurs on the first edge where Count ≥ T_HG−1 and FarmReq=1.
  - Count saturates at T_HG−1 while waiting.
  - Reset and Flash still override.
- TLC_SENSOR_EN undefined: FarmSensor is ignored, FarmReq is not built, and the cycle is fixed-time.

## Test plan
Benches use T_AR=2, T_HG=6, T_HY=3, T_FG=4, T_FY=3, T_FLASH=2.
- Reset release, no Flash → INIT for 2 cycles, then HG 6, HY 3, AR1 2, FG 4, FY 3, AR2 2, HG. Signal pairs per the state list, with HG re-entered 22 cycles after reset release.
- Flash asserted on the last cycle of HY → FLASH next (not AR1).
  - Outputs YELLOW/RED for 2 cycles, then OFF/OFF for 2 cycles, repeating.
  - Flash dropped → INIT RED/RED for 2 cycles, then HG.
- Rst_n pulsed low mid-FG between clock edges → outputs RED/RED and state=000 before the next Clk edge. After release, the cycle restarts at INIT.
- TLC_SENSOR_EN, FarmSensor=0 → HG holds indefinitely with Count stuck at 5.
  - A one-cycle FarmSensor pulse at cycle 20 of HG → HY on the next edge.
- TLC_SENSOR_EN, FarmSensor pulse during FY → FarmReq held. HG lasts exactly 6 cycles, then HY.
- Without TLC_SENSOR_EN, FarmSensor toggling randomly → sequence identical to the first scenario.
